// File: rtl/zero_detect_scheduler.sv
// zero_detect_scheduler
// Two requesters share one serial Mealy zero detector. A round-robin
// arbiter grants one requester in IDLE and captures its word. The word is
// shifted MSB-first through the detector, and detections are counted. A
// one-cycle done pulse, tagged with the owning requester, reports the
// final count.
module zero_detect_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             grant0,
    output logic             grant1,
    output logic             busy,
    output logic             x_out,
    output logic             y_out,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             owner
);

    // The bit counter must hold WIDTH-1, which is the index of the last bit.
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } ctrl_state_t;

    typedef enum logic [1:0] {
        D0,
        D1,
        D2,
        D3
    } det_state_t;

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    det_state_t       det_state;
    det_state_t       det_next;

    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic             ptr;
    logic             pick;
    logic             capture;
    logic             shift_en;
    logic             serial_bit;
    logic             det_y;

    assign serial_bit = shreg[WIDTH-1];

    // The detector flags a 0 that follows at least one 1. D0 means that no 1 is pending.
    assign det_y = (det_state != D0) && !serial_bit;

    // The detector output is visible only while a word is being shifted.
    assign y_out = shift_en & det_y;

    // Controller state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controller next state, arbitration and status outputs. Grants are gated by
    // reset so that every output is low while reset is asserted.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        pick       = 1'b0;
        capture    = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        x_out      = 1'b0;
        case (state)
            IDLE: begin
                if (reset && (req0 || req1)) begin
                    pick       = (req0 && req1) ? ptr : req1;
                    grant0     = ~pick;
                    grant1     = pick;
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                x_out    = serial_bit;
                if (bit_cnt == LAST_BIT) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Detector state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            det_state <= D0;
        end else begin
            det_state <= det_next;
        end
    end

    // Detector next state. It is forced to D0 at every grant, so no state carries from one word to the next.
    always_comb begin
        det_next = det_state;
        if (capture) begin
            det_next = D0;
        end else if (shift_en) begin
            if (!serial_bit) begin
                det_next = D0;
            end else begin
                case (det_state)
                    D0:      det_next = D1;
                    D1:      det_next = D3;
                    D3:      det_next = D2;
                    D2:      det_next = D2;
                    default: det_next = D0;
                endcase
            end
        end
    end

    // Datapath: word capture, shifting, detection counting and the round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            count   <= '0;
            owner   <= 1'b0;
            ptr     <= 1'b0;
        end else if (capture) begin
            shreg   <= pick ? data1 : data0;
            bit_cnt <= '0;
            count   <= '0;
            owner   <= pick;
        end else if (shift_en) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            count   <= count + {{(CNT_W-1){1'b0}}, y_out};
        end else if (done) begin
            ptr     <= ~owner;
        end
    end

endmodule
